// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer.
// Fetches a 16-bit instruction over a req/ack handshake, decodes it, runs an
// optional data-memory access and commits exactly one PC update per
// instruction. Outputs are decoded from the state and instruction registers;
// the branch condition flags are looked at only while committing.
module control_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        Z,
    input  logic        N,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  PS,
    output logic [5:0]  A,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  DR,
    output logic        RW,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic        fault
);

    // Opcode encodings (IR[15:12]); 8..F are undefined.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_BRZ = 4'h4;
    localparam logic [3:0] OP_BRN = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_HLT = 4'h7;

    // Watchdog counter sizing. The counter expires on the cycle in which it
    // holds ACK_TIMEOUT-1, i.e. after ACK_TIMEOUT cycles of waiting.
    localparam int CW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int LIMIT_I = (ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0;
    localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];
    localparam bit WD_EN = (ACK_TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [15:0]     ir_r;
    logic [CW-1:0]   wait_cnt_r;
    logic [3:0]      opcode_s;
    logic            wd_expire_s;
    logic            timeout_s;

    assign opcode_s    = ir_r[15:12];
    assign wd_expire_s = WD_EN && (wait_cnt_r == LIMIT);

    // State register: the only way out of HALT is the asynchronous reset.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an ack arriving on the expiry cycle takes priority.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    next_state_s = ST_DECODE;
                end else if (wd_expire_s) begin
                    next_state_s = ST_HALT;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode_s)
                    OP_HLT:  next_state_s = ST_HALT;
                    OP_LD:   next_state_s = ST_MEM;
                    OP_ST:   next_state_s = ST_MEM;
                    default: next_state_s = ST_COMMIT;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    next_state_s = ST_COMMIT;
                end else if (wd_expire_s) begin
                    next_state_s = ST_HALT;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_COMMIT: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Instruction register: captured on the accepted fetch.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            ir_r <= 16'h0000;
        end else if ((state_r == ST_FETCH) && imem_ack) begin
            ir_r <= instr;
        end
    end

    // Wait counter: counts unacknowledged request cycles, idles at zero so
    // every FETCH/MEM entry starts from a cleared count.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (((state_r == ST_FETCH) && !imem_ack) ||
                     ((state_r == ST_MEM) && !dmem_ack)) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {CW{1'b0}};
        end
    end

    // Sticky status: undefined opcode seen in DECODE, or handshake timeout.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if ((state_r == ST_DECODE) && opcode_s[3]) begin
                illegal <= 1'b1;
            end
            if (timeout_s) begin
                fault <= 1'b1;
            end
        end
    end

    // Output decode: PS and RW can only be non-zero in COMMIT, which gives
    // exactly one PC update per instruction and none on HLT.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        PS       = 2'b00;
        RW       = 1'b0;
        A        = ir_r[5:0];
        SA       = ir_r[7:4];
        SB       = ir_r[3:0];
        DR       = ir_r[11:8];
        busy     = (state_r != ST_IDLE) && (state_r != ST_HALT);
        halted   = (state_r == ST_HALT);
        case (state_r)
            ST_FETCH: imem_req = 1'b1;
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_s == OP_ST);
            end
            ST_COMMIT: begin
                case (opcode_s)
                    OP_ALU: begin
                        PS = 2'b01;
                        RW = 1'b1;
                    end
                    OP_LD: begin
                        PS = 2'b01;
                        RW = 1'b1;
                    end
                    OP_BRZ:  PS = Z ? 2'b10 : 2'b01;
                    OP_BRN:  PS = N ? 2'b10 : 2'b01;
                    OP_JMP:  PS = 2'b11;
                    OP_NOP:  PS = 2'b01;
                    default: PS = 2'b01;
                endcase
            end
            ST_IDLE:   PS = 2'b00;
            ST_DECODE: PS = 2'b00;
            ST_HALT:   PS = 2'b00;
            default:   PS = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: inputs driven and outputs sampled on
// the falling edge, expected values worked out by hand from the cycle plan.
module tb_control_sequencer;

    logic        clk_main = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        Z;
    logic        N;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic [1:0]  PS;
    logic [5:0]  A;
    logic [3:0]  SA;
    logic [3:0]  SB;
    logic [3:0]  DR;
    logic        RW;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        fault;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.ACK_TIMEOUT(4)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .run      (run),
        .instr    (instr),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .Z        (Z),
        .N        (N),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .PS       (PS),
        .A        (A),
        .SA       (SA),
        .SB       (SB),
        .DR       (DR),
        .RW       (RW),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .fault    (fault)
    );

    always #5 clk_main = ~clk_main;

    // All outputs packed into one word (28 bits) for the all-zero checks.
    logic [31:0] all_outs;
    assign all_outs = {4'h0, imem_req, dmem_req, dmem_we, PS, RW, busy, halted,
                       illegal, fault, A, SA, SB, DR};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        @(negedge clk_main);
    endtask

    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        instr    = 16'h0000;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        Z        = 1'b0;
        N        = 1'b0;
        @(negedge clk_main);
        @(negedge clk_main);
        chk("reset_outputs", all_outs, 32'h0);

        // ALU 0x1300, zero-wait fetch.
        reset    = 1'b1;
        run      = 1'b1;
        imem_ack = 1'b1;
        instr    = 16'h1300;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("alu_c1_req", {30'd0, imem_req, busy}, 32'd3);
        tick();
        chk("alu_c2_decode", {29'd0, imem_req, PS}, 32'd0);
        tick();
        chk("alu_c3_commit", {24'd0, RW, DR, PS, imem_req}, {24'd0, 1'b1, 4'd3, 2'b01, 1'b0});
        tick();
        chk("alu_c4_fetch", {31'd0, imem_req}, 32'd1);

        // BRZ 0x4025 taken.
        instr = 16'h4025;
        Z     = 1'b1;
        tick();
        tick();
        chk("brz_taken", {22'd0, PS, SA, SB}, {22'd0, 2'b10, 4'd2, 4'd5});
        tick();
        // BRZ 0x4025 not taken.
        Z = 1'b0;
        tick();
        tick();
        chk("brz_not_taken", {30'd0, PS}, 32'd1);
        tick();
        // JMP 0x6015.
        instr = 16'h6015;
        tick();
        tick();
        chk("jmp", {24'd0, PS, A}, {24'd0, 2'b11, 6'h15});
        tick();

        // LD 0x2A00 with dmem_ack delayed 3 cycles (ack on the expiry cycle).
        instr    = 16'h2A00;
        dmem_ack = 1'b0;
        tick();
        chk("ld_decode", {30'd0, dmem_req, RW}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ld_mem%0d", k), {30'd0, dmem_req, dmem_we}, 32'd2);
            if (k == 3) dmem_ack = 1'b1;
            tick();
        end
        chk("ld_commit", {23'd0, dmem_req, RW, PS, DR, fault},
            {23'd0, 1'b0, 1'b1, 2'b01, 4'hA, 1'b0});
        tick();

        // ST 0x3000, zero-wait.
        instr = 16'h3000;
        tick();
        tick();
        chk("st_mem", {30'd0, dmem_req, dmem_we}, 32'd3);
        tick();
        chk("st_commit", {28'd0, RW, PS, dmem_we}, {28'd0, 1'b0, 2'b01, 1'b0});
        tick();

        // Illegal 0x9000 executes as NOP.
        instr = 16'h9000;
        chk("illegal_clear", {31'd0, illegal}, 32'd0);
        tick();
        tick();
        chk("illegal_commit", {29'd0, illegal, PS}, {29'd0, 1'b1, 2'b01});
        tick();

        // HLT 0x7000.
        instr = 16'h7000;
        tick();
        tick();
        chk("hlt_state", {30'd0, halted, busy}, 32'd2);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hlt_hold%0d", k), {28'd0, PS, imem_req, halted}, 32'd1);
        end
        reset = 1'b0;
        #1;
        chk("hlt_reset", all_outs, 32'h0);

        // Reset asserted during MEM.
        @(negedge clk_main);
        reset    = 1'b1;
        instr    = 16'h2A00;
        dmem_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("mem_before_reset", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mem_async_reset", all_outs, 32'h0);
        @(negedge clk_main);
        reset = 1'b1;
        tick();
        chk("restart_fetch", {31'd0, imem_req}, 32'd1);

        // Fetch timeout after 4 waiting cycles.
        imem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_wait%0d", k), {29'd0, imem_req, fault, halted}, 32'd4);
            tick();
        end
        chk("timeout_fault", {29'd0, imem_req, fault, halted}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
